// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, initiator FSM encoding, request bundle and idle values.
package pci_pkg;

    localparam logic [3:0] READ_OP      = 4'b0110;
    localparam logic [3:0] WRITE_OP     = 4'b0111;
    localparam logic [3:0] PCI_IDLE_CBE = 4'hF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_TURN  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [3:0]  be;
    } pci_req_t;

    // A zero length still moves one word; oversize requests are cut to max_len.
    function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
        logic [5:0] res;
        res = len;
        if (len == 6'd0) begin
            res = 6'd1;
        end else if (len > max_len) begin
            res = max_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Local request/response handshake plus PCI control lines of the initiator (AD stays a port).
interface pci_initiator_if;

    logic        START;
    logic [31:0] ADDR;
    logic [3:0]  CMD;
    logic [3:0]  BE;
    logic [5:0]  LEN;
    logic [31:0] WDATA;
    logic        WR_ACK;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        BUSY;
    logic        DONE;
    logic        ABORT;
    logic        FRAME;
    logic        IRDY;
    logic [3:0]  CBE;
    logic        TRDY;
    logic        DEVSEL;

    modport master (
        input  START, ADDR, CMD, BE, LEN, WDATA, TRDY, DEVSEL,
        output WR_ACK, RDATA, RVALID, BUSY, DONE, ABORT, FRAME, IRDY, CBE
    );

    modport slave (
        output START, ADDR, CMD, BE, LEN, WDATA, TRDY, DEVSEL,
        input  WR_ACK, RDATA, RVALID, BUSY, DONE, ABORT, FRAME, IRDY, CBE
    );

endinterface

// File: rtl/pci_ad_driver.sv
// AD tri-state driver: registered output enable, address/write-data mux and read turnaround flag.
module pci_ad_driver
    import pci_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_state,
    input  logic [2:0]  i_state_nxt,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_turnaround,
    output logic [31:0] o_ad_in,
    inout  wire  [31:0] AD
);

    logic        r_oe;
    logic        r_turn;
    logic [31:0] w_ad_out;

    // Enable follows the next state so AD is owned exactly for the cycles we drive it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_oe   <= 1'b0;
            r_turn <= 1'b0;
        end else begin
            r_oe   <= (i_state_nxt == ST_ADDR) || ((i_state_nxt == ST_DATA) && i_write);
            r_turn <= (i_state == ST_ADDR) && (i_state_nxt == ST_DATA) && !i_write;
        end
    end

    assign w_ad_out     = (i_state == ST_ADDR) ? i_addr : i_wdata;
    assign AD           = r_oe ? w_ad_out : 32'hzzzz_zzzz;
    assign o_ad_in      = AD;
    assign o_turnaround = r_turn;

endmodule

// File: rtl/pci_initiator.sv
// PCI burst initiator: runs one read or write burst per request, ending in DONE or master ABORT.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int unsigned DEVSEL_TIMEOUT = 5,
    parameter int unsigned MAX_LEN        = 32
) (
    input  logic            CLK,
    input  logic            REST,
    pci_initiator_if.master bus,
    inout  wire  [31:0]     AD
);

    localparam logic [5:0] LP_MAX_LEN = 6'(MAX_LEN);
    localparam logic [7:0] LP_TMO     = 8'(DEVSEL_TIMEOUT);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    pci_req_t    r_req;
    logic [5:0]  r_remain;
    logic [7:0]  r_tmo;
    logic        r_dev_seen;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_done;

    logic        w_write;
    logic        w_final;
    logic        w_turn;
    logic        w_xfer;
    logic [31:0] w_ad_in;

    assign w_write = (r_req.cmd == WRITE_OP);
    assign w_final = (r_remain == 6'd1);
    assign w_xfer  = (r_state == ST_DATA) && !w_turn && !bus.TRDY;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.START) w_state_nxt = ST_ADDR;
            ST_ADDR:  w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_xfer) begin
                    if (w_final) w_state_nxt = ST_TURN;
                end else if (!r_dev_seen && bus.DEVSEL && ((r_tmo + 8'd1) == LP_TMO)) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: w_state_nxt = ST_TURN;
            ST_TURN:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!REST) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_remain   <= '0;
            r_tmo      <= '0;
            r_dev_seen <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            if ((r_state == ST_IDLE) && bus.START) begin
                r_req.addr <= bus.ADDR;
                r_req.cmd  <= bus.CMD;
                r_req.be   <= bus.BE;
                r_remain   <= clamp_len(bus.LEN, LP_MAX_LEN);
                r_tmo      <= '0;
                r_dev_seen <= 1'b0;
            end
            if (r_state == ST_DATA) begin
                if (w_xfer) begin
                    r_remain <= r_remain - 6'd1;
                    r_done   <= w_final;
                    if (!w_write) begin
                        r_rdata  <= w_ad_in;
                        r_rvalid <= 1'b1;
                    end
                end
                // Once a target claims the cycle the timeout is dead for this transaction.
                if (!bus.DEVSEL) begin
                    r_dev_seen <= 1'b1;
                    r_tmo      <= '0;
                end else if (!r_dev_seen) begin
                    r_tmo <= r_tmo + 8'd1;
                end
            end
        end
    end

    always_comb begin
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        bus.CBE   = PCI_IDLE_CBE;
        case (r_state)
            ST_ADDR: begin
                bus.FRAME = 1'b0;
                bus.CBE   = r_req.cmd;
            end
            ST_DATA: begin
                bus.FRAME = w_final;
                bus.IRDY  = 1'b0;
                bus.CBE   = r_req.be;
            end
            ST_ABORT: begin
                bus.IRDY = 1'b0;
                bus.CBE  = r_req.be;
            end
            default: ;
        endcase
    end

    assign bus.BUSY   = (r_state != ST_IDLE);
    assign bus.WR_ACK = w_xfer && w_write;
    assign bus.RVALID = r_rvalid;
    assign bus.RDATA  = r_rdata;
    assign bus.DONE   = r_done;
    assign bus.ABORT  = (r_state == ST_ABORT);

    pci_ad_driver u_ad_drv (
        .i_clk        (CLK),
        .i_rst_n      (REST),
        .i_state      (r_state),
        .i_state_nxt  (w_state_nxt),
        .i_write      (w_write),
        .i_addr       (r_req.addr),
        .i_wdata      (bus.WDATA),
        .o_turnaround (w_turn),
        .o_ad_in      (w_ad_in),
        .AD           (AD)
    );

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: behavioural target and local side, event scoreboard, directed bursts.
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int unsigned TMO = 5;

    logic clk  = 1'b0;
    logic rest = 1'b0;
    always #5 clk = ~clk;

    pci_initiator_if bus ();
    wire [31:0] ad;

    pci_initiator #(
        .DEVSEL_TIMEOUT (TMO),
        .MAX_LEN        (32)
    ) dut (
        .CLK  (clk),
        .REST (rest),
        .bus  (bus.master),
        .AD   (ad)
    );

    // Target model: claims addresses with ADDR[31:16]==0, word index from ADDR[7:2].
    logic [31:0] mem [64];
    logic        t_act;
    logic        t_write;
    logic        t_frame_q;
    logic [5:0]  t_base;
    logic [5:0]  t_idx;
    logic [3:0]  t_hold;
    int unsigned wait_cfg;

    assign bus.DEVSEL = !t_act;
    assign bus.TRDY   = !(t_act && (t_hold == 4'd0));
    assign ad = (t_act && !t_write && (t_hold == 4'd0)) ? mem[t_base + t_idx] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!rest) begin
            t_act     <= 1'b0;
            t_write   <= 1'b0;
            t_hold    <= 4'd0;
            t_idx     <= 6'd0;
            t_frame_q <= 1'b1;
        end else begin
            t_frame_q <= bus.FRAME;
            if (!t_act) begin
                if (!bus.FRAME && t_frame_q && (ad[31:16] == 16'h0)) begin
                    t_act   <= 1'b1;
                    t_write <= (bus.CBE == WRITE_OP);
                    t_base  <= ad[7:2];
                    t_idx   <= 6'd0;
                    t_hold  <= 4'(wait_cfg) + ((bus.CBE == WRITE_OP) ? 4'd0 : 4'd1);
                end
            end else if (t_hold != 4'd0) begin
                t_hold <= t_hold - 4'd1;
            end else if (!bus.IRDY) begin
                if (t_write) mem[t_base + t_idx] <= ad;
                t_idx <= t_idx + 6'd1;
                if (bus.FRAME) t_act <= 1'b0;
            end
        end
    end

    // Local side: next write word is presented after each WR_ACK edge.
    logic [31:0] wbuf [64];
    logic [5:0]  wq_rd = 6'd0;
    always @(posedge clk) if (bus.WR_ACK) wq_rd <= wq_rd + 6'd1;
    assign bus.WDATA = wbuf[wq_rd];

    typedef enum logic [1:0] {EvAck, EvRd, EvDone, EvAbort} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q [$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_e kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e kind, input logic [31:0] data, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event data %h, required no event", name, data);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.data !== data)) begin
                n_fail++;
                $display("FAIL %s: got kind %0d data %h, required kind %0d data %h",
                         name, kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.WR_ACK) observe(EvAck, bus.WDATA, "wr_ack");
        if (bus.RVALID) observe(EvRd, bus.RDATA, "rvalid");
        if (bus.DONE)   observe(EvDone, 32'h0, "done");
        if (bus.ABORT)  observe(EvAbort, 32'h0, "abort");
    end

    int         cyc, done_cyc, abort_cyc, frame_low, irdy_low, n_xfer;
    logic [7:0] xfer_frame;
    logic       turn_released, waits_stable, busy_cleared, irdy_at_done;

    task automatic start_req(input logic [31:0] a, input logic [3:0] c, input logic [5:0] len);
        @(negedge clk);
        bus.START = 1'b1;
        bus.ADDR  = a;
        bus.CMD   = c;
        bus.BE    = 4'h0;
        bus.LEN   = len;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [3:0] c,
                           input logic [5:0] len);
        logic [37:0] snap;
        logic [37:0] prev_snap;
        logic        prev_wait;
        start_req(a, c, len);
        check({tag, "_addr_ad"}, ad, a);
        check({tag, "_addr_cbe"}, {28'h0, bus.CBE}, {28'h0, c});
        frame_low     = bus.FRAME ? 0 : 1;
        irdy_low      = bus.IRDY ? 0 : 1;
        cyc           = 0;
        done_cyc      = 0;
        abort_cyc     = 0;
        n_xfer        = 0;
        xfer_frame    = 8'h0;
        turn_released = 1'b1;
        waits_stable  = 1'b1;
        busy_cleared  = 1'b0;
        irdy_at_done  = 1'b0;
        prev_wait     = 1'b0;
        prev_snap     = '0;
        while (!busy_cleared && (cyc < 60)) begin
            @(negedge clk);
            cyc++;
            if (!bus.BUSY) begin
                busy_cleared = 1'b1;
            end else begin
                snap = {bus.FRAME, bus.IRDY, bus.CBE, (c == WRITE_OP) ? ad : 32'h0};
                if (prev_wait && (snap != prev_snap)) waits_stable = 1'b0;
                prev_wait = !bus.IRDY && bus.TRDY && !bus.DEVSEL;
                prev_snap = snap;
                if (!bus.FRAME) frame_low++;
                if (!bus.IRDY) irdy_low++;
                if ((cyc == 1) && (c == READ_OP) && dut.u_ad_drv.r_oe) turn_released = 1'b0;
                if (!bus.IRDY && !bus.TRDY) begin
                    xfer_frame[n_xfer[2:0]] = bus.FRAME;
                    n_xfer++;
                end
                if (bus.DONE) begin
                    done_cyc     = cyc;
                    irdy_at_done = bus.IRDY;
                end
                if (bus.ABORT) abort_cyc = cyc;
            end
        end
        check({tag, "_busy_clear"}, {31'h0, busy_cleared}, 32'h1);
        check({tag, "_sb_empty"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    initial begin
        bus.START = 1'b0;
        bus.ADDR  = '0;
        bus.CMD   = '0;
        bus.BE    = '0;
        bus.LEN   = '0;
        wait_cfg  = 0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {24'h0, bus.FRAME, bus.IRDY, bus.BUSY, bus.DONE, bus.ABORT,
                          bus.RVALID, bus.WR_ACK, dut.u_ad_drv.r_oe}, 32'hC0);
        check("rst_cbe", {28'h0, bus.CBE}, 32'hF);
        check("rst_rdata", bus.RDATA, 32'h0);
        rest = 1'b1;

        // Write burst, LEN=3
        wbuf[wq_rd]     = 32'h0000_00A0;
        wbuf[wq_rd + 1] = 32'h0000_00A1;
        wbuf[wq_rd + 2] = 32'h0000_00A2;
        push_ev(EvAck, 32'hA0);
        push_ev(EvAck, 32'hA1);
        push_ev(EvAck, 32'hA2);
        push_ev(EvDone, 32'h0);
        run_txn("wr3", 32'h0000_FFFF, WRITE_OP, 6'd3);
        check("wr3_nxfer", n_xfer, 32'd3);
        check("wr3_frame_at_xfer", {24'h0, xfer_frame}, 32'h4);
        check("wr3_done_cyc", done_cyc, 32'd4);
        check("wr3_mem0", mem[63], 32'hA0);
        check("wr3_mem1", mem[0], 32'hA1);
        check("wr3_mem2", mem[1], 32'hA2);

        // Read burst, LEN=2, of the words just written
        push_ev(EvRd, 32'hA0);
        push_ev(EvRd, 32'hA1);
        push_ev(EvDone, 32'h0);
        run_txn("rd2", 32'h0000_FFFF, READ_OP, 6'd2);
        check("rd2_turn_released", {31'h0, turn_released}, 32'h1);
        check("rd2_frame_at_xfer", {24'h0, xfer_frame}, 32'h2);
        check("rd2_done_cyc", done_cyc, 32'd4);
        check("rd2_irdy_in_turn", {31'h0, irdy_at_done}, 32'h1);

        // Single word write
        wbuf[wq_rd] = 32'h5A5A_0001;
        push_ev(EvAck, 32'h5A5A_0001);
        push_ev(EvDone, 32'h0);
        run_txn("wr1", 32'h0000_0010, WRITE_OP, 6'd1);
        check("wr1_frame_low", frame_low, 32'd1);
        check("wr1_irdy_low", irdy_low, 32'd1);
        check("wr1_done_cyc", done_cyc, 32'd2);
        check("wr1_mem", mem[4], 32'h5A5A_0001);

        // Master abort: nobody decodes this address
        wbuf[wq_rd]     = 32'hDEAD_0000;
        wbuf[wq_rd + 1] = 32'hDEAD_0001;
        push_ev(EvAbort, 32'h0);
        run_txn("abort", 32'h1234_5678, WRITE_OP, 6'd2);
        check("abort_cyc", abort_cyc, TMO + 1);
        check("abort_nxfer", n_xfer, 32'd0);
        check("abort_no_done", done_cyc, 32'd0);

        // Wait states: TRDY held high for three cycles with DEVSEL asserted
        wait_cfg = 3;
        wbuf[wq_rd]     = 32'h0000_00C0;
        wbuf[wq_rd + 1] = 32'h0000_00C1;
        push_ev(EvAck, 32'hC0);
        push_ev(EvAck, 32'hC1);
        push_ev(EvDone, 32'h0);
        run_txn("wait", 32'h0000_0040, WRITE_OP, 6'd2);
        wait_cfg = 0;
        check("wait_stable", {31'h0, waits_stable}, 32'h1);
        check("wait_no_abort", abort_cyc, 32'd0);
        check("wait_done_cyc", done_cyc, 32'd6);
        check("wait_mem0", mem[16], 32'hC0);
        check("wait_mem1", mem[17], 32'hC1);

        // Reset during the second word of a LEN=4 write
        wbuf[wq_rd]     = 32'h0000_00B0;
        wbuf[wq_rd + 1] = 32'h0000_00B1;
        wbuf[wq_rd + 2] = 32'h0000_00B2;
        wbuf[wq_rd + 3] = 32'h0000_00B3;
        push_ev(EvAck, 32'hB0);
        push_ev(EvAck, 32'hB1);
        start_req(32'h0000_0020, WRITE_OP, 6'd4);
        @(negedge clk);
        @(negedge clk);
        rest = 1'b0;
        @(negedge clk);
        check("rst_mid_ctl", {27'h0, bus.FRAME, bus.IRDY, bus.BUSY, bus.DONE,
                              dut.u_ad_drv.r_oe}, 32'h18);
        rest = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_sb_empty", exp_q.size(), 32'h0);
        check("rst_mid_mem", mem[8], 32'hB0);

        // New request after reset; LEN=0 behaves as a single word
        push_ev(EvRd, 32'hB0);
        push_ev(EvDone, 32'h0);
        run_txn("rd_after_rst", 32'h0000_0020, READ_OP, 6'd0);
        check("rd_after_rst_nxfer", n_xfer, 32'd1);
        check("rd_after_rst_done_cyc", done_cyc, 32'd3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
